// File: rtl/alu_cmd_sequencer.sv
// Collects an A/B/opcode frame from the UART receiver, drives the ALU and hands the result to the transmitter.
// Build option: define ALU_SEQ_TIMEOUT_EN to compile in the inter-byte timeout that abandons partial frames.
module alu_cmd_sequencer #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned NB_TMO         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    // Elaboration-time guard on the timeout configuration
    if (TIMEOUT_CYCLES < 2 || 64'(TIMEOUT_CYCLES) >= (64'(1) << NB_TMO)) begin : g_bad_cfg
        $error("alu_cmd_sequencer: TIMEOUT_CYCLES out of range for NB_TMO");
    end

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYCLES - 1);
    logic [NB_TMO-1:0] tmo_cnt_q, tmo_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        tmo_cnt_d  = '0;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_WAIT_A: if (i_rx_done) begin
                alu_a_d = i_rx_data;
                state_d = ST_WAIT_B;
            end
            ST_WAIT_B: if (i_rx_done) begin
                alu_b_d = i_rx_data;
                state_d = ST_WAIT_OP;
            end
            ST_WAIT_OP: if (i_rx_done) begin
                alu_op_d = i_rx_data[NB_OP-1:0];
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: if (i_tx_done) begin
                state_d = ST_WAIT_A;
            end
            default: state_d = ST_WAIT_A;
        endcase

        // Bytes arriving while a result is in flight are dropped
        if (i_rx_done && (state_q == ST_EXEC || state_q == ST_SEND || state_q == ST_WAIT_TX)) begin
            overrun_d = 1'b1;
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        // A byte in the terminal-count cycle wins over the abandon
        if ((state_q == ST_WAIT_B || state_q == ST_WAIT_OP) && !i_rx_done) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d   = ST_WAIT_A;
                timeout_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + NB_TMO'(1);
            end
        end
`endif

        busy_d = (state_d != ST_WAIT_A);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: frame-level reference model, behavioural ALU and UART transmitter.
module tb_alu_cmd_sequencer;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;
    localparam int unsigned NB_TMO  = 16;
    localparam int unsigned TMO     = 16;

    logic               CLOCK = 1'b0;
    logic               RESET_N;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] o_alu_a, o_alu_b, o_tx_data;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic               o_tx_start, i_tx_done, o_busy, o_overrun, o_timeout;

    alu_cmd_sequencer #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TMO(NB_TMO), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_timeout(o_timeout)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_exp = 0, ovr_seen = 0, tmo_exp = 0, tmo_seen = 0;
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [7:0] mon_d;
    int         mon_c;
    logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    // MIPS-style ALU function used both as the environment ALU and the frame-level reference
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT requests a transmission
    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (o_overrun) ovr_seen++;
            if (o_timeout) tmo_seen++;
            if (o_tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_start", 64'd1, 64'd0);
                end else begin
                    mon_d = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    chk("tx_data", 64'(o_tx_data), 64'(mon_d));
                    chk("tx_start_cycle", 64'(mon_c), 64'(cyc));
                end
            end
        end
    end

    // Transmitter model: done pulse 5 cycles after each start
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (RESET_N && o_tx_start) begin
                repeat (5) @(negedge CLOCK);
                i_tx_done = 1'b1;
                @(negedge CLOCK);
                i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge CLOCK);
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        exp_q.push_back(alu_ref(a, b, op[5:0]));
        exp_cyc_q.push_back(cyc + 2);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int gap);
        send_byte(a);
        repeat (gap) @(negedge CLOCK);
        send_byte(b);
        repeat (gap) @(negedge CLOCK);
        send_byte(op);
        push_exp(a, b, op);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && o_busy; k++) @(negedge CLOCK);
        if (o_busy) chk("idle_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        chk("outputs_in_reset",
            64'({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun, o_timeout}), 64'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    initial begin
        int n;
        int d;
        logic [7:0] ra, rb, rop;
        RESET_N   = 1'b0;
        i_rx_done = 1'b0;
        i_rx_data = '0;
        repeat (2) @(negedge CLOCK);
        chk("reset_values",
            64'({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun, o_timeout}), 64'd0);
        RESET_N = 1'b1;
        @(negedge CLOCK);

        // ADD frame with busy window
        send_byte(8'h03);
        chk("busy_after_first_byte", 64'(o_busy), 64'd1);
        send_byte(8'h02);
        send_byte(8'h20);
        push_exp(8'h03, 8'h02, 8'h20);
        n = cyc;
        chk("alu_op_add", 64'(o_alu_op), 64'h20);
        repeat (7) @(negedge CLOCK);
        chk("busy_until_tx_done", 64'(o_busy), 64'd1);
        @(negedge CLOCK);
        chk("idle_after_tx_done", 64'(o_busy), 64'd0);
        chk("turnaround_cycle", 64'(cyc - n), 64'd8);

        // AND frame, then opcode with upper bits set
        send_frame(8'h03, 8'h02, 8'h24, 0);
        chk("alu_op_and", 64'(o_alu_op), 64'h24);
        wait_idle();
        send_frame(8'h03, 8'h02, 8'hA4, 0);
        chk("alu_op_upper_dropped", 64'(o_alu_op), 64'h24);
        wait_idle();

        // Byte arriving in WAIT_TX is dropped
        send_frame(8'h10, 8'h20, 8'h20, 1);
        repeat (3) @(negedge CLOCK);
        send_byte(8'h55);
        ovr_exp++;
        chk("overrun_pulse", 64'(o_overrun), 64'd1);
        @(negedge CLOCK);
        chk("overrun_one_cycle", 64'(o_overrun), 64'd0);
        chk("overrun_keeps_busy", 64'(o_busy), 64'd1);
        chk("overrun_operand_kept", 64'(o_alu_a), 64'h10);
        wait_idle();
        send_frame(8'h01, 8'h01, 8'h20, 0);
        wait_idle();

`ifdef ALU_SEQ_TIMEOUT_EN
        // Abandon in WAIT_B after TMO idle cycles
        send_byte(8'h07);
        repeat (TMO - 1) @(negedge CLOCK);
        chk("no_timeout_early", 64'(o_timeout), 64'd0);
        chk("busy_before_timeout", 64'(o_busy), 64'd1);
        @(negedge CLOCK);
        chk("timeout_pulse", 64'(o_timeout), 64'd1);
        chk("idle_after_timeout", 64'(o_busy), 64'd0);
        tmo_exp++;
        send_frame(8'h04, 8'h01, 8'h22, 0);
        wait_idle();

        // Byte in terminal-count cycle is accepted
        send_byte(8'h09);
        repeat (TMO - 1) @(negedge CLOCK);
        send_byte(8'h5A);
        chk("terminal_no_timeout", 64'(o_timeout), 64'd0);
        chk("terminal_b_latched", 64'(o_alu_b), 64'h5A);
        chk("terminal_still_busy", 64'(o_busy), 64'd1);
        send_byte(8'h20);
        push_exp(8'h09, 8'h5A, 8'h20);
        wait_idle();

        // Abandon in WAIT_OP
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TMO) @(negedge CLOCK);
        chk("timeout_wait_op", 64'(o_timeout), 64'd1);
        tmo_exp++;
        @(negedge CLOCK);
`else
        // Without the timeout the FSM waits indefinitely
        send_byte(8'h07);
        repeat (1000) @(negedge CLOCK);
        chk("no_abandon_busy", 64'(o_busy), 64'd1);
        chk("no_abandon_timeout", 64'(tmo_seen), 64'd0);
        send_byte(8'h01);
        send_byte(8'h22);
        push_exp(8'h07, 8'h01, 8'h22);
        wait_idle();
`endif

        // Reset in WAIT_OP
        send_byte(8'h33);
        send_byte(8'h44);
        do_reset();
        repeat (3) @(negedge CLOCK);
        chk("idle_after_reset_wait_op", 64'(o_busy), 64'd0);
        send_frame(8'h03, 8'h02, 8'h20, 0);
        wait_idle();

        // Reset in WAIT_TX
        send_frame(8'h0F, 8'h01, 8'h20, 0);
        repeat (4) @(negedge CLOCK);
        do_reset();
        repeat (8) @(negedge CLOCK);
        chk("idle_after_reset_wait_tx", 64'(o_busy), 64'd0);
        send_frame(8'h03, 8'h02, 8'h20, 0);
        wait_idle();

        // Randomized frames with occasional dropped bytes
        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom), ops[$urandom_range(0, 7)]};
            send_frame(ra, rb, rop, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(0, 4);
                repeat (d) @(negedge CLOCK);
                send_byte(8'($urandom));
                ovr_exp++;
            end
            wait_idle();
        end

        repeat (4) @(negedge CLOCK);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        chk("overrun_count", 64'(ovr_seen), 64'(ovr_exp));
        chk("timeout_count", 64'(tmo_seen), 64'(tmo_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer between the UART byte receiver/transmitter and the combinational ALU. It collects a three-byte frame from the receive stream: operand A, operand B, then opcode. It holds those values stable on the ALU inputs, registers the ALU result, and hands it to the UART transmitter with a start/done handshake. It replaces ad-hoc byte counting in the UART glue with one explicit FSM, an optional inter-byte timeout and overrun reporting.

## Interface
- NB_DATA, 8, width of UART bytes, operands and result
- NB_OP, 6, opcode width driven to the ALU; the low NB_OP bits of the opcode byte are used
- NB_TMO, 16, width of the inter-byte timeout counter
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clock cycles; must be ≥2 and <2^NB_TMO

- CLOCK  in  1  single system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- o_alu_a  out  NB_DATA  registered operand A to the ALU
- o_alu_b  out  NB_DATA  registered operand B to the ALU
- o_alu_op  out  NB_OP  registered opcode to the ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- o_tx_data  out  NB_DATA  registered result for the transmitter
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- i_tx_done  in  1  one-cycle pulse when the transmitter has finished
- o_busy  out  1  high in every state except WAIT_A
- o_overrun  out  1  one-cycle pulse when a received byte is dropped
- o_timeout  out  1  one-cycle pulse when a partial frame is abandoned

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A + i_rx_done: o_alu_a <= i_rx_data, go to WAIT_B.
- WAIT_B + i_rx_done: o_alu_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP + i_rx_done: o_alu_op <= i_rx_data[NB_OP-1:0], go to EXEC. Upper bits of the opcode byte are ignored.
- EXEC: o_tx_data <= i_alu_result, go to SEND. This captures the result one full cycle after the opcode is registered.
- SEND: o_tx_start=1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: hold state until i_tx_done, then go to WAIT_A. i_tx_done in any other state is ignored.
- Operand, opcode and result registers hold their value until overwritten, so the ALU inputs stay stable across frames.
- i_rx_done in EXEC, SEND or WAIT_TX: the byte is dropped, o_overrun pulses on the next cycle, and the state is unchanged.
- Timeout counter, only when compiled in:
  - Cleared on every accepted byte and in WAIT_A, EXEC, SEND and WAIT_TX.
  - Increments each cycle in WAIT_B and WAIT_OP.
  - On reaching TIMEOUT_CYCLES-1 with no i_rx_done: go to WAIT_A, pulse o_timeout, clear the counter. Captured operands are kept but will be overwritten.
  - i_rx_done in the terminal-count cycle wins: the byte is accepted and no timeout occurs.

## Timing
- Reset values (RESET_N low, asynchronous): state WAIT_A; o_alu_a, o_alu_b, o_alu_op and o_tx_data are 0; o_tx_start, o_busy, o_overrun and o_timeout are 0; counter is 0.
- Reset asserted mid-frame or mid-transmission aborts immediately. No o_tx_start is issued after reset release until a new full frame has arrived.
- Opcode byte accepted at edge n:
  - o_alu_op is valid after n.
  - o_tx_data is valid after n+1.
  - o_tx_start is high between n+2 and n+3.
- Minimum frame-to-frame turnaround: one cycle after i_tx_done, at which point WAIT_A accepts a byte.
- o_overrun and o_timeout are registered outputs, high for exactly one cycle per event.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined: the timeout counter and abandon logic are compiled in, as described above.
- ALU_SEQ_TIMEOUT_EN undefined: no counter is instantiated, the FSM waits indefinitely in WAIT_B and WAIT_OP, and o_timeout is tied 0.

## Test plan
- Bytes 0x03, 0x02, 0x20 with ALU ADD; i_tx_done 5 cycles after o_tx_start. Required: o_tx_data=0x05, a single o_tx_start pulse 2 cycles after the opcode edge, o_busy high from the first byte until i_tx_done.
- Bytes 0x03, 0x02, 0x24 (AND). Required: o_tx_data=0x02, o_alu_op=0x24. Then send 0xA4 as the opcode: o_alu_op=0x24 (upper bits dropped).
- i_rx_done=1 with 0x55 during WAIT_TX. Required: o_overrun pulses once, no state change, and the following frame 0x01, 0x01, 0x20 yields 0x02.
- Macro defined, TIMEOUT_CYCLES=16: send 0x07, then idle 16 cycles. Required: o_timeout pulses once and the state is WAIT_A. The next bytes 0x04, 0x01, 0x22 (SUB) yield 0x03. Repeat without the macro: no abandon after 1000 idle cycles.
- Macro defined: i_rx_done coincides with the terminal count in WAIT_B. Required: the byte is latched as operand B, there is no o_timeout, and the state is WAIT_OP.
- RESET_N pulsed low in WAIT_OP and in WAIT_TX. Required: all outputs 0 during reset, no o_tx_start afterwards, and the next frame 0x03, 0x02, 0x20 yields 0x05.
